// File: rtl/mux_channel_sequencer.sv
// Channel register bank and select sequencer feeding the 4:1 channel multiplexer.
// Scans the enabled channels with a programmable dwell, free-running or single-stepped.
module mux_channel_sequencer #(
   parameter int unsigned WIDTH   = 8,
   parameter int unsigned DWELL_W = 8
) (
   input  logic               Clock,
   input  logic               Reset,
   input  logic               WrEn,
   input  logic [1:0]         WrAddr,
   input  logic [WIDTH-1:0]   WrData,
   input  logic               Run,
   input  logic               Step,
   input  logic [DWELL_W-1:0] Dwell,
   input  logic [3:0]         ChanMask,
   output logic [WIDTH-1:0]   A,
   output logic [WIDTH-1:0]   B,
   output logic [WIDTH-1:0]   C,
   output logic [WIDTH-1:0]   D,
   output logic [1:0]         Select,
   output logic               SelStrobe,
   output logic               Active
);

   typedef enum logic [0:0] {IDLE = 1'b0, SCAN = 1'b1} state_t;

   state_t             state, state_nxt;
   logic [DWELL_W-1:0] cnt, cnt_nxt;
   logic [1:0]         sel_nxt;
   logic               strobe_nxt;
   logic               active_nxt;
   logic               adv;

   // First enabled channel after s, wrapping back to s itself; s when nothing is enabled.
   function automatic logic [1:0] nxt_chan(input logic [1:0] s, input logic [3:0] m);
      logic [1:0] c1, c2, c3;
      c1 = s + 2'd1;
      c2 = s + 2'd2;
      c3 = s + 2'd3;
      if (m[c1])      return c1;
      else if (m[c2]) return c2;
      else if (m[c3]) return c3;
      else            return s;
   endfunction

   always_ff @(posedge Clock) begin
      if (Reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (Run)  state_nxt = SCAN;
         SCAN:    if (!Run) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Dwell counting and advance decisions; the Run transition always wins over an advance.
   always_comb begin
      adv     = 1'b0;
      cnt_nxt = cnt;
      case (state)
         IDLE: begin
            cnt_nxt = '0;
            if (!Run && Step) adv = 1'b1;
         end
         SCAN: begin
            if (!Run) begin
               cnt_nxt = '0;
            end else if (cnt >= Dwell) begin
               adv     = 1'b1;
               cnt_nxt = '0;
            end else begin
               cnt_nxt = cnt + DWELL_W'(1);
            end
         end
         default: cnt_nxt = '0;
      endcase
      sel_nxt    = adv ? nxt_chan(Select, ChanMask) : Select;
      strobe_nxt = (sel_nxt != Select);
      active_nxt = (state_nxt == SCAN);
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         cnt       <= '0;
         Select    <= 2'd0;
         SelStrobe <= 1'b0;
         Active    <= 1'b0;
      end else begin
         cnt       <= cnt_nxt;
         Select    <= sel_nxt;
         SelStrobe <= strobe_nxt;
         Active    <= active_nxt;
      end
   end

   // Channel registers are written independently of the scan state.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         A <= '0;
         B <= '0;
         C <= '0;
         D <= '0;
      end else if (WrEn) begin
         case (WrAddr)
            2'd0:    A <= WrData;
            2'd1:    B <= WrData;
            2'd2:    C <= WrData;
            default: D <= WrData;
         endcase
      end
   end

endmodule

// File: tb/tb_mux_channel_sequencer.sv
// Directed bench for mux_channel_sequencer: writes, scan order, stepping, dwell changes, masks, reset.
module tb_mux_channel_sequencer;

   localparam int unsigned WIDTH   = 8;
   localparam int unsigned DWELL_W = 8;

   logic               Clock = 1'b0;
   logic               Reset;
   logic               WrEn;
   logic [1:0]         WrAddr;
   logic [WIDTH-1:0]   WrData;
   logic               Run;
   logic               Step;
   logic [DWELL_W-1:0] Dwell;
   logic [3:0]         ChanMask;
   logic [WIDTH-1:0]   A, B, C, D;
   logic [1:0]         Select;
   logic               SelStrobe;
   logic               Active;

   int checks = 0;
   int errors = 0;

   mux_channel_sequencer #(.WIDTH(WIDTH), .DWELL_W(DWELL_W)) dut (
      .Clock(Clock), .Reset(Reset), .WrEn(WrEn), .WrAddr(WrAddr), .WrData(WrData),
      .Run(Run), .Step(Step), .Dwell(Dwell), .ChanMask(ChanMask),
      .A(A), .B(B), .C(C), .D(D),
      .Select(Select), .SelStrobe(SelStrobe), .Active(Active)
   );

   always #5 Clock = ~Clock;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge Clock);
      #1;
   endtask

   task automatic chk_sel(input string tag, input logic [1:0] s, input logic st, input logic act);
      chk({tag, ".sel"}, 32'(Select), 32'(s));
      chk({tag, ".stb"}, 32'(SelStrobe), 32'(st));
      chk({tag, ".act"}, 32'(Active), 32'(act));
   endtask

   logic [1:0] seq4 [13] = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2,
                             2'd3, 2'd3, 2'd3, 2'd0};
   logic [1:0] seq_ab [6] = '{2'd0, 2'd1, 2'd3, 2'd1, 2'd3, 2'd1};
   logic [7:0] wvals [4]  = '{8'h11, 8'h22, 8'h33, 8'h44};

   initial begin
      Reset = 1'b1; WrEn = 1'b0; WrAddr = 2'd0; WrData = '0;
      Run = 1'b0; Step = 1'b0; Dwell = '0; ChanMask = 4'b0000;
      tick();
      tick();
      chk("rst.abcd", {A, B, C, D}, 32'h0);
      chk_sel("rst", 2'd0, 1'b0, 1'b0);
      Reset = 1'b0;

      // Register writes, one per cycle
      for (int i = 0; i < 4; i++) begin
         WrEn = 1'b1; WrAddr = 2'(i); WrData = wvals[i];
         tick();
         chk($sformatf("wr%0d", i), {A, B, C, D},
             {wvals[0], (i >= 1) ? wvals[1] : 8'h0, (i >= 2) ? wvals[2] : 8'h0, (i >= 3) ? wvals[3] : 8'h0});
         chk_sel($sformatf("wr%0d", i), 2'd0, 1'b0, 1'b0);
      end
      WrEn = 1'b0;

      // Full mask, dwell 2: each channel held 3 cycles
      ChanMask = 4'b1111; Dwell = 8'd2; Run = 1'b1;
      for (int i = 0; i < 13; i++) begin
         tick();
         chk_sel($sformatf("scan4[%0d]", i), seq4[i],
                 (i > 0) && (seq4[i] != seq4[i-1]), 1'b1);
      end
      Run = 1'b0;
      tick();
      chk_sel("stop1", 2'd0, 1'b0, 1'b0);

      // Mask 1010, dwell 0: toggles between 1 and 3
      ChanMask = 4'b1010; Dwell = 8'd0; Run = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick();
         chk_sel($sformatf("scan13[%0d]", i), seq_ab[i], i > 0, 1'b1);
      end
      Run = 1'b0;
      tick();
      chk_sel("stop2", 2'd1, 1'b0, 1'b0);

      // Single stepping in IDLE
      ChanMask = 4'b0110;
      Step = 1'b1; tick(); chk_sel("step1", 2'd2, 1'b1, 1'b0);
      Step = 1'b0; tick(); chk_sel("step1q", 2'd2, 1'b0, 1'b0);
      Step = 1'b1; tick(); chk_sel("step2", 2'd1, 1'b1, 1'b0);
      Step = 1'b0; tick(); chk_sel("step2q", 2'd1, 1'b0, 1'b0);
      Step = 1'b1; Run = 1'b1; tick(); chk_sel("steprun", 2'd1, 1'b0, 1'b1);
      Step = 1'b0; Run = 1'b0; tick(); chk_sel("steprunq", 2'd1, 1'b0, 1'b0);

      // Lowering Dwell below the count forces an advance
      ChanMask = 4'b1111; Dwell = 8'd10; Run = 1'b1;
      tick(); chk_sel("d10.entry", 2'd1, 1'b0, 1'b1);
      for (int i = 1; i <= 7; i++) begin
         tick();
         chk_sel($sformatf("d10.c%0d", i), 2'd1, 1'b0, 1'b1);
      end
      Dwell = 8'd3; tick(); chk_sel("d3.adv", 2'd2, 1'b1, 1'b1);
      Dwell = 8'd10; tick(); tick(); chk_sel("d10.hold", 2'd2, 1'b0, 1'b1);
      Run = 1'b0; tick(); chk_sel("d10.stop", 2'd2, 1'b0, 1'b0);

      // Empty mask freezes Select; write during scan; reset mid-scan
      ChanMask = 4'b0000; Dwell = 8'd0; Run = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk_sel($sformatf("nomask[%0d]", i), 2'd2, 1'b0, 1'b1);
      end
      WrEn = 1'b1; WrAddr = 2'd2; WrData = 8'h5A;
      tick(); WrEn = 1'b0;
      chk("scanwr", {A, B, C, D}, 32'h11225A44);
      ChanMask = 4'b1111; tick(); chk_sel("remask", 2'd3, 1'b1, 1'b1);
      Reset = 1'b1; tick();
      chk("midrst.abcd", {A, B, C, D}, 32'h0);
      chk_sel("midrst", 2'd0, 1'b0, 1'b0);
      Reset = 1'b0; Run = 1'b0;
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

endmodule

// File: doc/mux_channel_sequencer.md
Name: mux_channel_sequencer

Overview:
- Upstream feeder for the 4:1 8-bit channel multiplexer.
- Holds four 8-bit channel registers, loaded through a write port.
- Presents the registers continuously on A/B/C/D.
- Generates the 2-bit Select that scans the enabled channels with a programmable dwell time, in free-run or single-step mode.

Parameters:
WIDTH, 8, data width of each channel register and of WrData/A/B/C/D
DWELL_W, 8, width of the Dwell input and of the internal dwell counter

Ports:
Clock  input  1  rising-edge clock for all state
Reset  input  1  synchronous, active-high; clears all state at the next rising edge of Clock
WrEn  input  1  write strobe for the channel registers
WrAddr  input  2  channel register index (0=A, 1=B, 2=C, 3=D)
WrData  input  WIDTH  write data
Run  input  1  level; 1 = free-running scan
Step  input  1  single-cycle request to advance one channel while not running
Dwell  input  DWELL_W  channel is held Dwell+1 cycles per visit
ChanMask  input  4  bit i = 1 means channel i participates in the scan
A, B, C, D  output  WIDTH  channel registers 0..3, driven directly from flops
Select  output  2  current channel index, driven from a flop
SelStrobe  output  1  one-cycle pulse in the cycle Select takes a new value
Active  output  1  1 while in SCAN state

Behaviour:
- Reset values: A=B=C=D=0, Select=0, SelStrobe=0, Active=0, dwell counter=0, state=IDLE.
- Write port:
  - WrEn=1 loads WrData into register WrAddr at the edge; the new value is visible on the output the following cycle.
  - Writes are accepted in every state, including to the currently selected channel.
  - Writes never affect Select or the counter.
- Next-channel function nxt(s): first index with ChanMask bit set, searched in order s+1, s+2, s+3, s (mod 4). If ChanMask=0, nxt(s)=s.
- An "advance" sets Select<=nxt(Select) and clears the counter. SelStrobe=1 in the cycle after the edge only if the value actually changed.
- FSM, 2 states:
  - IDLE:
    - Active=0; counter held at 0.
    - Run=1 -> SCAN at the next edge. Counter starts at 0; Select is unchanged on entry.
    - Run=0 and Step=1 -> one advance at the next edge; remain IDLE.
  - SCAN:
    - Active=1.
    - Each cycle: if counter >= Dwell, advance; else counter<=counter+1.
    - Comparison is against the live Dwell. Lowering Dwell below the current count forces an advance at the next edge.
    - Run=0 -> IDLE at the next edge. Counter<=0, Select holds its current value, no advance in that cycle.
- Priority within a cycle: Reset > Run transitions > advance > Step. Step is ignored in SCAN and ignored when Run=1 in IDLE.
- Dwell=0: a channel changes every cycle in SCAN.
- Counter wrap: unreachable because of the >= compare. The counter never exceeds max(Dwell) held.
- ChanMask edge cases:
  - ChanMask=0: Select frozen, SelStrobe stays 0, counter still cycles.
  - Only the current channel enabled: Select stays, no strobe.
  - Mask changes mid-dwell: take effect at the next advance only. The current channel is not abandoned early even if its bit is cleared.
- Reset asserted mid-scan: the next edge restores all reset values, including register contents.
- All outputs are registered. No combinational path exists from any input to any output.

Test Plan:
- Reset, then write A=0x11, B=0x22, C=0x33, D=0x44 on consecutive cycles -> each output shows its value one cycle after its write; Select=0, Active=0, SelStrobe=0 throughout.
- ChanMask=4'b1111, Dwell=2, Run=1 -> Select goes 0,0,0,1,1,1,2,2,2,3,3,3,0…, each value held 3 cycles from the first SCAN cycle. SelStrobe pulses once per change, including at the 3->0 wrap.
- ChanMask=4'b1010, Dwell=0, Run=1 from Select=0 -> Select 0 then 1,3,1,3… every cycle; channels 0 and 2 are never revisited.
- Run=0, ChanMask=4'b0110, Select=1: Step pulse -> Select=2 next cycle with one SelStrobe. Second Step -> Select=1. Step with Run=1 -> no extra advance.
- SCAN with Dwell=10 and counter at 7: change Dwell to 3 -> advance at the next edge. Drop Run mid-dwell -> Active=0 next cycle, Select unchanged, no strobe.
- ChanMask=0 during SCAN -> Select frozen, SelStrobe never asserted. Assert Reset mid-scan -> all outputs 0 the cycle after.
